staff_recorder: RTL and testbench
=================================

# staff_recorder

Converts a live MIDI note-event stream into the staff note memory format: up to 5 simultaneous voices quantized onto 64 sixteenth-note time cells. It sits between the MIDI receiver and the staff display/playback path. Its `note_memory` output and `valid_staff_out` pulse drive the playback side's staff memory and valid-staff inputs, so a recorded performance can be shown and replayed.

## Interface

No parameters; geometry is fixed at 5 voices × 64 cells × 12 bits.

- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  reset; asynchronous, active-low (0 = reset)
- record_in  input  1  level; high arms and holds a recording pass
- clear_in  input  1  one-cycle pulse; zeroes memory, frees all voices, cell counter to 0
- tick_in  input  1  one-cycle pulse per sixteenth-note step (from tempo counter)
- midi_data_ready_in  input  1  one-cycle pulse; event fields below valid this cycle
- midi_status_in  input  1  1 = note-on, 0 = note-off
- midi_received_note_in  input  8  MIDI note number; bit 7 ignored
- midi_velocity_in  input  8  velocity; note-on with velocity 0 is treated as note-off
- note_memory  output  12 × [4:0][63:0]  staff memory; [3:0] octave, [7:4] note kind 0–11, [11:8] duration (1 = sounding sixteenth, 0 = rest)
- valid_staff_out  output  1  one-cycle pulse when 64 cells have been written
- cell_addr_out  output  6  next cell to be written
- recording_out  output  1  high in RECORD
- voices_active_out  output  3  number of held voice slots, 0–5
- overflow_out  output  1  sticky; a note-on was dropped because all 5 slots were full

## Operation

- Voice tracker:
  - 5 slots, each holding {active, note[6:0]}.
  - The tracker updates on every `midi_data_ready_in` in all states.
- Note-on handling:
  - If the note is already held in any slot, the event is ignored (no duplicate allocation).
  - Otherwise the note goes into the lowest-index free slot.
  - If no slot is free, the note is dropped and `overflow_out` is set.
- Note-off handling: clears the slot holding that note; a note-off for an unheld note is ignored.
- Encoding:
  - octave = note / 12 (0–10); kind = note % 12. Both are computed with combinational compare/subtract, with no divider IP.
  - Sounding cell = {4'd1, kind, octave}; empty slot = 12'h000.
- FSM states IDLE, RECORD, DONE:
  - IDLE → RECORD when `record_in` = 1. On entry, `cell_addr_out` is set to 0. Slots are kept, so notes held before arming are recorded.
  - RECORD, on `tick_in`: write column `cell_addr_out` for all 5 voices from the current slot state, then increment the cell.
  - RECORD: the write of cell 63 → DONE, `valid_staff_out` = 1 for one cycle, `cell_addr_out` wraps to 0.
  - RECORD with `record_in` = 0 → IDLE. There is no valid pulse, partial contents are kept, and `cell_addr_out` holds its value.
  - DONE → IDLE when `record_in` = 0. Ticks in IDLE and DONE are ignored.
- `clear_in`:
  - Zeroes all 320 entries, frees all slots, clears `overflow_out`, and sets the cell to 0, in any state.
  - It does not change the FSM state.
  - It wins over a same-cycle tick or MIDI event.

## Timing

- Reset (`rst_in` = 0, async): all `note_memory` = 12'h000, slots free, state IDLE, `valid_staff_out` = 0, `cell_addr_out` = 0, `recording_out` = 0, `voices_active_out` = 0, `overflow_out` = 0. Reset mid-RECORD aborts immediately.
- MIDI event at cycle t: slot and `voices_active_out` updated at t+1.
- Tick at cycle t: the column is written from the slot state as registered at t, so a same-cycle MIDI event is not reflected until the next tick. `note_memory` and `cell_addr_out` are updated at t+1.
- `valid_staff_out` is high at t+1 after the tick that writes cell 63, and `recording_out` falls the same cycle.
- Back-to-back ticks (every cycle) are supported; each tick writes exactly one cell.

## Test plan

- Reset: hold `rst_in` = 0, then release → all 320 entries 12'h000, all outputs 0, state IDLE.
- `record_in` = 1; note-on 60 vel 100; 4 ticks; note-off 60; 60 ticks:
  - voice 0 cells 0–3 = 12'h105, all other cells 12'h000;
  - `valid_staff_out` pulses exactly once, one cycle after the 64th tick;
  - `cell_addr_out` = 0, state DONE.
- Note-ons 60–65 on consecutive cycles, then 1 tick:
  - voices 0–4 = 12'h105, 12'h115, 12'h125, 12'h135, 12'h145;
  - 65 dropped; `overflow_out` = 1; `voices_active_out` = 5.
- Event edge cases:
  - note-on 72 vel 0 after note-on 72 → slot freed;
  - duplicate note-on 67 → one slot only;
  - note-off 40 when not held → no change.
- Tick and note-on 48 in the same cycle: that cell shows 12'h000 for the voice; the next tick's cell = 12'h104.
- Aborts:
  - drop `record_in` at cell 10 → IDLE, no valid pulse, cells 0–9 retained, `cell_addr_out` = 10;
  - `clear_in` → all zero, cell 0;
  - assert `rst_in` = 0 mid-RECORD → immediate reset values.

Source files
------------

// File: rtl/staff_recorder_if.sv
// rtl/staff_recorder_if.sv - MIDI note-event bundle from the receiver into the staff recorder
interface staff_recorder_if;
  logic       midi_data_ready_in;
  logic       midi_status_in;
  logic [7:0] midi_received_note_in;
  logic [7:0] midi_velocity_in;

  modport master (
    output midi_data_ready_in,
    output midi_status_in,
    output midi_received_note_in,
    output midi_velocity_in
  );

  modport slave (
    input midi_data_ready_in,
    input midi_status_in,
    input midi_received_note_in,
    input midi_velocity_in
  );
endinterface

// File: rtl/staff_recorder.sv
// rtl/staff_recorder.sv - records held MIDI notes into a 5-voice x 64-cell staff memory
module staff_recorder (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   record_in,
  input  logic                   clear_in,
  input  logic                   tick_in,
  staff_recorder_if.slave        midi,
  output logic [4:0][63:0][11:0] note_memory,
  output logic                   valid_staff_out,
  output logic [5:0]             cell_addr_out,
  output logic                   recording_out,
  output logic [2:0]             voices_active_out,
  output logic                   overflow_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic start_rec;
  logic write_cell;
  logic last_cell;
  logic tick_eff;

  logic [4:0]       slot_active;
  logic [4:0][6:0]  slot_note;
  logic [4:0]       hit;
  logic             free_found;
  logic [2:0]       free_idx;
  logic [6:0]       note7;
  logic             note_on;
  logic [4:0][11:0] column;

  // Octave/kind by repeated compare-subtract; 127 needs at most 10 steps.
  function automatic logic [11:0] encode(input logic [6:0] n);
    logic [6:0] rem;
    logic [3:0] oct;
    rem = n;
    oct = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (rem >= 7'd12) begin
        rem = rem - 7'd12;
        oct = oct + 4'd1;
      end
    end
    return {4'd1, 4'(rem), oct};
  endfunction

  // A clear in the same cycle suppresses the tick entirely.
  assign tick_eff = tick_in & ~clear_in;

  always_comb begin
    state_nxt  = state;
    start_rec  = 1'b0;
    write_cell = 1'b0;
    last_cell  = 1'b0;
    case (state)
      IDLE: begin
        if (record_in) begin
          state_nxt = RECORD;
          start_rec = 1'b1;
        end
      end
      RECORD: begin
        if (!record_in) begin
          state_nxt = IDLE;
        end else if (tick_eff) begin
          write_cell = 1'b1;
          if (cell_addr_out == 6'd63) begin
            last_cell = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!record_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  assign note7   = midi.midi_received_note_in[6:0];
  assign note_on = midi.midi_status_in && (midi.midi_velocity_in != 8'd0);

  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      hit[i] = slot_active[i] && (slot_note[i] == note7);
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_active  <= '0;
      slot_note    <= '0;
      overflow_out <= 1'b0;
    end else if (clear_in) begin
      slot_active  <= '0;
      slot_note    <= '0;
      overflow_out <= 1'b0;
    end else if (midi.midi_data_ready_in) begin
      if (note_on) begin
        if (!(|hit)) begin
          if (free_found) begin
            slot_active[free_idx] <= 1'b1;
            slot_note[free_idx]   <= note7;
          end else begin
            overflow_out <= 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (hit[i]) slot_active[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      column[i] = slot_active[i] ? encode(slot_note[i]) : 12'h000;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      note_memory     <= '0;
      cell_addr_out   <= 6'd0;
      valid_staff_out <= 1'b0;
    end else begin
      valid_staff_out <= last_cell;
      if (clear_in) begin
        note_memory   <= '0;
        cell_addr_out <= 6'd0;
      end else if (start_rec) begin
        cell_addr_out <= 6'd0;
      end else if (write_cell) begin
        for (int v = 0; v < 5; v++) begin
          note_memory[v][cell_addr_out] <= column[v];
        end
        cell_addr_out <= cell_addr_out + 6'd1;
      end
    end
  end

  always_comb begin
    voices_active_out = 3'd0;
    for (int i = 0; i < 5; i++) begin
      voices_active_out = voices_active_out + {2'b00, slot_active[i]};
    end
  end

  assign recording_out = (state == RECORD);

endmodule

// File: tb/tb_staff_recorder.sv
// tb/tb_staff_recorder.sv - scoreboard bench for staff_recorder
module tb_staff_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic record;
  logic clear;
  logic tick;

  logic [4:0][63:0][11:0] note_memory;
  logic                   valid_out;
  logic [5:0]             cell_addr;
  logic                   recording;
  logic [2:0]             voices_active;
  logic                   overflow;

  staff_recorder_if midi();

  staff_recorder dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .record_in         (record),
    .clear_in          (clear),
    .tick_in           (tick),
    .midi              (midi),
    .note_memory       (note_memory),
    .valid_staff_out   (valid_out),
    .cell_addr_out     (cell_addr),
    .recording_out     (recording),
    .voices_active_out (voices_active),
    .overflow_out      (overflow)
  );

  typedef struct {
    string name;
    int    sel;
    int    idx;
    int    exp;
  } exp_t;

  localparam int SEL_MEM = 0, SEL_CELL = 1, SEL_REC = 2, SEL_VA = 3, SEL_OVF = 4, SEL_VALID = 5;

  exp_t        sb_q[$];
  int          valid_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        sample_req = 1'b0;
  logic [11:0] exp_mem [320];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int sel, int idx);
    case (sel)
      SEL_MEM:   return int'(note_memory[idx / 64][idx % 64]);
      SEL_CELL:  return int'(cell_addr);
      SEL_REC:   return int'(recording);
      SEL_VA:    return int'(voices_active);
      SEL_OVF:   return int'(overflow);
      default:   return int'(valid_out);
    endcase
  endfunction

  // Monitor: pops expectations on sample requests and checks every valid pulse.
  always @(negedge clk) begin
    exp_t it;
    int   a;
    int   e;
    if (valid_out) begin
      checks++;
      if (valid_q.size() == 0) begin
        errors++;
        $display("FAIL valid_pulse unexpected at cycle %0d", cyc);
      end else begin
        e = valid_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL valid_pulse_cycle actual=%0d required=%0d", cyc, e);
        end
      end
    end
    if (sample_req) begin
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        a  = actual(it.sel, it.idx);
        checks++;
        if (a != it.exp) begin
          errors++;
          $display("FAIL %s[%0d] actual=%0h required=%0h", it.name, it.idx, a, it.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push(string n, int sel, int idx, int e);
    exp_t it;
    it.name = n; it.sel = sel; it.idx = idx; it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic push_mem_all(string n);
    for (int i = 0; i < 320; i++) push(n, SEL_MEM, i, int'(exp_mem[i]));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 320; i++) exp_mem[i] = 12'h000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check();
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_midi(bit on, int note, int vel);
    midi.midi_data_ready_in    = 1'b1;
    midi.midi_status_in        = on;
    midi.midi_received_note_in = 8'(note);
    midi.midi_velocity_in      = 8'(vel);
    step();
    midi.midi_data_ready_in    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; record = 1'b0; clear = 1'b0; tick = 1'b0;
    midi.midi_data_ready_in = 1'b0; midi.midi_status_in = 1'b0;
    midi.midi_received_note_in = 8'd0; midi.midi_velocity_in = 8'd0;
    clear_exp();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    push_mem_all("reset_mem");
    push("reset_cell", SEL_CELL, 0, 0);
    push("reset_rec", SEL_REC, 0, 0);
    push("reset_va", SEL_VA, 0, 0);
    push("reset_ovf", SEL_OVF, 0, 0);
    push("reset_valid", SEL_VALID, 0, 0);
    check();

    // Full pass: note 60 for 4 cells then rests to cell 63
    record = 1'b1;
    step();
    do_midi(1, 60, 100);
    push("pass_va", SEL_VA, 0, 1);
    push("pass_rec", SEL_REC, 0, 1);
    check();
    repeat (4) do_tick();
    do_midi(0, 60, 0);
    for (int i = 0; i < 60; i++) begin
      if (i == 59) valid_q.push_back(cyc + 1);
      do_tick();
    end
    for (int c = 0; c < 4; c++) exp_mem[c] = 12'h105;
    push_mem_all("pass_mem");
    push("pass_cell_wrap", SEL_CELL, 0, 0);
    push("pass_done_rec", SEL_REC, 0, 0);
    push("pass_done_va", SEL_VA, 0, 0);
    check();
    do_tick();
    push("done_tick_cell", SEL_CELL, 0, 0);
    push("done_tick_mem", SEL_MEM, 0, 12'h105);
    check();

    // Six note-ons into five slots
    record = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    clear_exp();
    record = 1'b1;
    step();
    midi.midi_data_ready_in = 1'b1;
    midi.midi_status_in     = 1'b1;
    midi.midi_velocity_in   = 8'd100;
    for (int n = 60; n <= 65; n++) begin
      midi.midi_received_note_in = 8'(n);
      step();
    end
    midi.midi_data_ready_in = 1'b0;
    do_tick();
    exp_mem[0 * 64] = 12'h105;
    exp_mem[1 * 64] = 12'h115;
    exp_mem[2 * 64] = 12'h125;
    exp_mem[3 * 64] = 12'h135;
    exp_mem[4 * 64] = 12'h145;
    push_mem_all("poly_mem");
    push("poly_va", SEL_VA, 0, 5);
    push("poly_ovf", SEL_OVF, 0, 1);
    push("poly_cell", SEL_CELL, 0, 1);
    push("poly_rec", SEL_REC, 0, 1);
    check();

    // Event edge cases
    for (int n = 60; n <= 65; n++) do_midi(0, n, 0);
    push("alloff_va", SEL_VA, 0, 0);
    push("alloff_ovf_sticky", SEL_OVF, 0, 1);
    check();
    do_midi(1, 72, 100);
    push("on72_va", SEL_VA, 0, 1);
    check();
    do_midi(1, 72, 0);
    push("vel0_off_va", SEL_VA, 0, 0);
    check();
    do_midi(1, 67, 100);
    do_midi(1, 67, 90);
    push("dup_va", SEL_VA, 0, 1);
    check();
    do_midi(0, 40, 0);
    push("unheld_off_va", SEL_VA, 0, 1);
    check();
    do_tick();
    exp_mem[1] = 12'h175;
    push_mem_all("dup_mem");
    push("dup_cell", SEL_CELL, 0, 2);
    check();
    do_midi(0, 67, 0);

    // Tick and note-on in the same cycle
    tick = 1'b1;
    midi.midi_data_ready_in    = 1'b1;
    midi.midi_status_in        = 1'b1;
    midi.midi_received_note_in = 8'd48;
    midi.midi_velocity_in      = 8'd100;
    step();
    tick = 1'b0;
    midi.midi_data_ready_in = 1'b0;
    do_tick();
    exp_mem[3] = 12'h104;
    push_mem_all("same_cycle_mem");
    push("same_cycle_cell", SEL_CELL, 0, 4);
    check();
    do_midi(0, 48, 0);

    // Abort at cell 10
    do_midi(1, 50, 100);
    repeat (6) do_tick();
    for (int c = 4; c < 10; c++) exp_mem[c] = 12'h124;
    record = 1'b0;
    step();
    push_mem_all("abort_mem");
    push("abort_cell", SEL_CELL, 0, 10);
    push("abort_rec", SEL_REC, 0, 0);
    check();
    do_tick();
    push("idle_tick_cell", SEL_CELL, 0, 10);
    push("idle_tick_mem", SEL_MEM, 10, 0);
    check();

    // Clear beats a same-cycle tick and note-on
    clear = 1'b1;
    tick  = 1'b1;
    midi.midi_data_ready_in    = 1'b1;
    midi.midi_status_in        = 1'b1;
    midi.midi_received_note_in = 8'd55;
    midi.midi_velocity_in      = 8'd100;
    step();
    clear = 1'b0;
    tick  = 1'b0;
    midi.midi_data_ready_in = 1'b0;
    clear_exp();
    push_mem_all("clear_mem");
    push("clear_cell", SEL_CELL, 0, 0);
    push("clear_va", SEL_VA, 0, 0);
    push("clear_ovf", SEL_OVF, 0, 0);
    check();

    // Reset mid-RECORD
    record = 1'b1;
    step();
    do_midi(1, 60, 100);
    repeat (3) do_tick();
    rst_n = 1'b0;
    push_mem_all("midrst_mem");
    push("midrst_cell", SEL_CELL, 0, 0);
    push("midrst_rec", SEL_REC, 0, 0);
    push("midrst_va", SEL_VA, 0, 0);
    push("midrst_ovf", SEL_OVF, 0, 0);
    push("midrst_valid", SEL_VALID, 0, 0);
    check();
    record = 1'b0;
    rst_n  = 1'b1;
    repeat (3) step();

    checks++;
    if (valid_q.size() != 0) begin
      errors++;
      $display("FAIL valid_pulse_missing actual=%0d pending required=0", valid_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
